// File: rtl/relu_pkg.sv
// Shared types and default geometry for the ReLU stream controller.
// Both the interface and the datapath import this package.
package relu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_LANES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Beat-index width: at least one bit, even for a single-beat job.
  function automatic int addr_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/relu_stream_ctrl_if.sv
// Source-buffer read port and downstream valid/ready stream for relu_stream_ctrl.
// The controller side uses the master modport.
interface relu_stream_ctrl_if
  import relu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANES = DEF_LANES
);

  localparam int AW = addr_width(DEPTH / LANES);

  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [WIDTH*LANES-1:0] rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*LANES-1:0] out_data;
  logic                   out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/relu_lane.sv
// Single-element rectifier: negative two's-complement inputs become zero.
// The sign bit is also exported so the parent can count zeroed elements.
module relu_lane
  import relu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             neg
);

  assign neg  = din[WIDTH-1];
  assign dout = neg ? '0 : din;

endmodule

// File: rtl/relu_stream_ctrl.sv
// Reads one job of BEATS beats from a source buffer, rectifies every lane and
// streams the result through a 2-entry FIFO with valid/ready backpressure.
module relu_stream_ctrl
  import relu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] neg_count,
  relu_stream_ctrl_if.master         bus
);

  localparam int BEATS = DEPTH / LANES;
  localparam int AW    = addr_width(BEATS);
  localparam int NW    = $clog2(DEPTH + 1);
  localparam int BW    = WIDTH * LANES;
  localparam logic [AW-1:0] LAST_ADDR = AW'(BEATS - 1);

  state_t         state, state_nxt;
  logic [AW-1:0]  rd_addr;
  logic           rd_en;
  logic           accept;
  logic           last_issue;
  logic           room;
  logic           inflight;
  logic           inflight_last;

  logic [BW-1:0]    rect_data;
  logic [LANES-1:0] neg_flags;
  logic [NW-1:0]    neg_sum;

  logic [BW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          fifo_valid;
  logic          push, pop;
  logic          head_last;

  assign busy       = (state != ST_IDLE) || done;
  assign accept     = start && !busy;
  assign fifo_valid = (fifo_cnt != 2'd0);
  assign pop        = fifo_valid && bus.out_ready;
  assign push       = inflight;
  assign head_last  = fifo_last[rd_ptr];
  assign last_issue = rd_en && (rd_addr == LAST_ADDR);

  // Entries held plus beats still returning from the buffer must leave a free
  // slot for the read issued now; a pop this cycle frees one.
  assign room = ({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        rd_en = room;
        if (room && (rd_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && head_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The address parks on the last beat instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                     rd_addr <= '0;
    else if (accept)             rd_addr <= '0;
    else if (rd_en && !last_issue) rd_addr <= rd_addr + 1'b1;
  end

  // Read return tracking; clearing it on reset drops data still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= last_issue;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    relu_lane #(.WIDTH(WIDTH)) u_lane (
      .din  (bus.rd_data[WIDTH*i +: WIDTH]),
      .dout (rect_data[WIDTH*i +: WIDTH]),
      .neg  (neg_flags[i])
    );
  end

  always_comb begin
    neg_sum = '0;
    for (int i = 0; i < LANES; i++) neg_sum = neg_sum + NW'(neg_flags[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      fifo_last <= 2'b00;
    end else begin
      if (push) begin
        wr_ptr            <= ~wr_ptr;
        fifo_last[wr_ptr] <= inflight_last;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: payload storage is not reset; it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= rect_data;
  end

  always_ff @(posedge clk) begin
    if (rst)         neg_count <= '0;
    else if (accept) neg_count <= '0;
    else if (push)   neg_count <= neg_count + neg_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (state == ST_DRAIN) && pop && head_last;
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_last  = fifo_valid && head_last;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench for relu_stream_ctrl (WIDTH=32, DEPTH=64, LANES=8): full-negative,
// alternating-sign, backpressure, ignored restart and mid-job reset jobs.
module tb_relu_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] neg_count;

  relu_stream_ctrl_if #(.WIDTH(32), .DEPTH(64), .LANES(8)) bus ();

  relu_stream_ctrl #(.WIDTH(32), .DEPTH(64), .LANES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .neg_count (neg_count),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  logic [255:0] src       [8];
  logic [255:0] exp_beats [8];

  logic [255:0] got_data [$];
  logic         got_last [$];
  int           rd_log   [$];
  int           done_cnt;
  int           done_cyc;
  logic         done_busy;
  int           first_xfer_cyc;
  int           last_xfer_cyc;
  logic         stall_prev;
  logic [255:0] prev_data;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source buffer: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
  end

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.rd_en) rd_log.push_back(int'(bus.rd_addr));
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        if (got_data.size() == 1) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (stall_prev && bus.out_valid) check("stall_hold", bus.out_data, prev_data);
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_last.delete();
    rd_log.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, output int idle_cyc);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    idle_cyc = cyc;
    check({tag, "_timeout"}, n < 200, 1'b1);
  endtask

  task automatic wait_read(input int a, input string tag);
    int n;
    n = 0;
    while (!(bus.rd_en && bus.rd_addr == 3'(a)) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < 50, 1'b1);
  endtask

  task automatic check_job(input string tag, input int exp_neg);
    check({tag, "_nbeats"}, got_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), got_data[i], exp_beats[i]);
        check($sformatf("%s_last%0d", tag, i), got_last[i], (i == 7));
      end
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_nreads"}, rd_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rd_log.size()) check($sformatf("%s_addr%0d", tag, i), rd_log[i], i);
    end
    check({tag, "_neg_count"}, neg_count, exp_neg);
  endtask

  task automatic load_alternating();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        src[b][32*i +: 32]       = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        exp_beats[b][32*i +: 32] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h0000_0000;
      end
    end
  endtask

  task automatic load_indexed();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 7; i++) begin
        src[b][32*i +: 32]       = {8'h00, 8'(b), 8'(i), 8'h5A};
        exp_beats[b][32*i +: 32] = {8'h00, 8'(b), 8'(i), 8'h5A};
      end
      src[b][224 +: 32]       = {8'h80, 8'(b), 8'h07, 8'h5A};
      exp_beats[b][224 +: 32] = 32'h0000_0000;
    end
  endtask

  int idle_cyc;

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.out_ready = 1'b0;
    stall_prev    = 1'b0;
    done_cnt      = 0;
    for (int b = 0; b < 8; b++) src[b] = '0;
    tick();
    tick();

    check("rst_busy",      busy,          1'b0);
    check("rst_done",      done,          1'b0);
    check("rst_rd_en",     bus.rd_en,     1'b0);
    check("rst_rd_addr",   bus.rd_addr,   3'd0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_neg_count", neg_count,     7'd0);
    rst = 1'b0;
    tick();

    // Job 1: all elements negative, ready held high.
    for (int b = 0; b < 8; b++) begin
      src[b]       = {256{1'b1}};
      exp_beats[b] = '0;
    end
    bus.out_ready = 1'b1;
    clear_logs();
    pulse_start();
    check("j1_busy_after_start", busy,          1'b1);
    check("j1_first_rd_en",      bus.rd_en,     1'b1);
    check("j1_first_rd_addr",    bus.rd_addr,   3'd0);
    check("j1_valid_lat0",       bus.out_valid, 1'b0);
    tick();
    check("j1_valid_lat1",       bus.out_valid, 1'b0);
    tick();
    check("j1_valid_lat2",       bus.out_valid, 1'b1);
    run_to_idle("j1", idle_cyc);
    check_job("j1", 64);
    check("j1_throughput", last_xfer_cyc - first_xfer_cyc, 7);
    check("j1_done_timing", done_cyc, last_xfer_cyc + 1);
    check("j1_busy_at_done", done_busy, 1'b1);
    check("j1_busy_drop", idle_cyc, done_cyc + 1);

    // Job 2: alternating max-positive / min-negative lanes.
    load_alternating();
    clear_logs();
    pulse_start();
    run_to_idle("j2", idle_cyc);
    check_job("j2", 32);

    // Job 3: ready toggling every cycle.
    load_indexed();
    clear_logs();
    pulse_start();
    begin
      int n;
      n = 0;
      while (busy && n < 200) begin
        bus.out_ready = ~bus.out_ready;
        tick();
        n++;
      end
      check("j3_timeout", n < 200, 1'b1);
    end
    bus.out_ready = 1'b1;
    check_job("j3", 8);

    // Job 4: ready low for 20 cycles after start.
    bus.out_ready = 1'b0;
    clear_logs();
    pulse_start();
    for (int k = 0; k < 20; k++) tick();
    check("j4_reads_stalled", rd_log.size(), 2);
    check("j4_rd_en_low",     bus.rd_en,     1'b0);
    check("j4_out_valid",     bus.out_valid, 1'b1);
    check("j4_busy",          busy,          1'b1);
    bus.out_ready = 1'b1;
    run_to_idle("j4", idle_cyc);
    check_job("j4", 8);

    // Job 5: second start while the job is reading beat 3.
    clear_logs();
    pulse_start();
    wait_read(3, "j5_wait3");
    pulse_start();
    check("j5_next_addr", bus.rd_addr, 3'd4);
    run_to_idle("j5", idle_cyc);
    check_job("j5", 8);
    tick();
    tick();
    check("j5_no_restart", busy, 1'b0);

    // Job 6: reset while beat 4 is being read, then a clean job.
    load_alternating();
    clear_logs();
    pulse_start();
    wait_read(4, "j6_wait4");
    rst = 1'b1;
    tick();
    check("j6_rst_busy",      busy,          1'b0);
    check("j6_rst_done",      done,          1'b0);
    check("j6_rst_rd_en",     bus.rd_en,     1'b0);
    check("j6_rst_rd_addr",   bus.rd_addr,   3'd0);
    check("j6_rst_out_valid", bus.out_valid, 1'b0);
    check("j6_rst_out_last",  bus.out_last,  1'b0);
    check("j6_rst_neg_count", neg_count,     7'd0);
    rst = 1'b0;
    clear_logs();
    tick();
    check("j6_discard_valid", bus.out_valid, 1'b0);
    tick();
    tick();
    check("j6_discard_valid2", bus.out_valid, 1'b0);
    check("j6_no_done",        done_cnt,      0);
    pulse_start();
    run_to_idle("j6", idle_cyc);
    check_job("j6", 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
